// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file slice.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_NREGS  = 32;
  localparam int RF_NRD    = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  function automatic int rf_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/WB/debug-side bundle of the register file; master drives addresses and writes.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [ADDR_W-1:0]     dbg_addr;
  logic [DATA_W-1:0]     dbg_data;
  logic                  init_done;

  modport master (
    output rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data, dbg_addr,
    input  rd_data, rd_busy, dbg_data, init_done
  );

  modport slave (
    input  rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data, dbg_addr,
    output rd_data, rd_busy, dbg_data, init_done
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write tracker: issue marks a destination busy, WB clears it; per-port stall hints.
module regfile_scoreboard #(
  parameter int NREGS   = 32,
  parameter int ADDR_W  = 5,
  parameter bit ZERO_R0 = 1'b1,
  parameter int NRD     = 2,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_i,
  input  logic                  iss_en_i,
  input  logic [ADDR_W-1:0]     iss_addr_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [NRD*ADDR_W-1:0] rd_addr_i,
  output logic [NRD-1:0]        rd_busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NREGS);
  endfunction

  // Clear first, then set, so a new producer issued alongside WB keeps the entry busy
  always_comb begin
    busy_d = busy_q;
    if (run_i && wr_en_i && in_range(wr_addr_i))
      busy_d[wr_addr_i] = 1'b0;
    if (run_i && iss_en_i && in_range(iss_addr_i) && !(ZERO_R0 && iss_addr_i == '0))
      busy_d[iss_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr_i[i*ADDR_W +: ADDR_W];
    assign rd_busy_o[i] = run_i && in_range(ra) && busy_q[ra]
                          && !(BYPASS && wr_en_i && wr_addr_i == ra);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with WB bypass, optional zero r0, busy scoreboard
// and a post-reset clear sweep so the array needs no reset flops.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int NREGS   = RF_NREGS,
  parameter int ADDR_W  = rf_clog2(NREGS),
  parameter int NRD     = RF_NRD,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              run;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NREGS);
  endfunction

  function automatic logic readable(input logic [ADDR_W-1:0] a);
    return in_range(a) && !(ZERO_R0 && a == '0);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // The single array write port is shared between the clear sweep and WB
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = '0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(NREGS-1)) begin
          state_d   = RUN;
          clr_ptr_d = '0;
        end
      end
      RUN: begin
        if (bus.wr_en && readable(bus.wr_addr)) begin
          mem_we    = 1'b1;
          mem_waddr = bus.wr_addr;
          mem_wdata = bus.wr_data;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign run           = (state_q == RUN);
  assign bus.init_done = run;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    assign ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
    always_comb begin
      rdat = '0;
      if (run && readable(ra)) begin
        if (BYPASS && bus.wr_en && bus.wr_addr == ra) rdat = bus.wr_data;
        else                                          rdat = mem_q[ra];
      end
    end
    assign bus.rd_data[i*DATA_W +: DATA_W] = rdat;
  end

  // Debug sees the committed array only, never the in-flight WB value
  assign bus.dbg_data = (run && in_range(bus.dbg_addr)) ? mem_q[bus.dbg_addr] : '0;

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W),
    .ZERO_R0(ZERO_R0),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .run_i     (run),
    .iss_en_i  (bus.iss_en),
    .iss_addr_i(bus.iss_addr),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .rd_addr_i (bus.rd_addr),
    .rd_busy_o (bus.rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: config A (32 regs, 2 ports, bypass) and config B (16 regs, 4 ports, no bypass)
// share one stimulus stream and are checked against an array-based reference.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) ifa ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .NRD(4)) ifb ();

  regfile_mp #(.DATA_W(32), .NREGS(32), .ADDR_W(5), .NRD(2), .ZERO_R0(1'b1), .BYPASS(1'b1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  regfile_mp #(.DATA_W(32), .NREGS(16), .ADDR_W(4), .NRD(4), .ZERO_R0(1'b1), .BYPASS(1'b0))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int checks = 0;
  int errors = 0;

  logic [4:0]  s_rd [4];
  logic        s_iss_en, s_wr_en;
  logic [4:0]  s_iss_addr, s_wr_addr, s_dbg;
  logic [31:0] s_wr_data;

  logic [31:0] mem [2][32];
  bit          bsy [2][32];
  int          clr [2];

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          ie;
    logic [4:0]  ia;
    logic [4:0]  r0, r1, dbg;
    logic [31:0] a0, a1;
    bit          abz;
    logic [31:0] adbg;
    logic [31:0] b0, b1;
    bit          bbz;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(bit we, logic [4:0] wa, logic [31:0] wd, bit ie, logic [4:0] ia,
                              logic [4:0] r0, logic [4:0] r1, logic [4:0] dbg,
                              logic [31:0] a0, logic [31:0] a1, bit abz, logic [31:0] adbg,
                              logic [31:0] b0, logic [31:0] b1, bit bbz);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.r0 = r0; v.r1 = r1; v.dbg = dbg;
    v.a0 = a0; v.a1 = a1; v.abz = abz; v.adbg = adbg;
    v.b0 = b0; v.b1 = b1; v.bbz = bbz;
    return v;
  endfunction

  // ---------------- reference model ----------------
  function automatic int nr(int d);    return (d == 0) ? 32 : 16; endfunction
  function automatic bit byp(int d);   return (d == 0);           endfunction
  function automatic int ad(int d, logic [4:0] x);
    return (d == 0) ? int'(x) : int'(x[3:0]);
  endfunction
  function automatic bit mrun(int d);  return clr[d] >= nr(d);     endfunction

  function automatic logic [31:0] exp_rd(int d, logic [4:0] x);
    int a = ad(d, x);
    if (!mrun(d) || a == 0 || a >= nr(d)) return 32'h0;
    if (byp(d) && s_wr_en && ad(d, s_wr_addr) == a) return s_wr_data;
    return mem[d][a];
  endfunction

  function automatic bit exp_busy(int d, logic [4:0] x);
    int a = ad(d, x);
    if (!mrun(d) || a >= nr(d)) return 1'b0;
    if (byp(d) && s_wr_en && ad(d, s_wr_addr) == a) return 1'b0;
    return bsy[d][a];
  endfunction

  function automatic logic [31:0] exp_dbg(int d);
    if (!mrun(d)) return 32'h0;
    return mem[d][ad(d, s_dbg)];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      clr[d] = 0;
      for (int r = 0; r < 32; r++) begin
        mem[d][r] = 32'h0;
        bsy[d][r] = 1'b0;
      end
    end
  endtask

  task automatic model_clock();
    for (int d = 0; d < 2; d++) begin
      if (!mrun(d)) clr[d]++;
      else begin
        if (s_wr_en) begin
          if (ad(d, s_wr_addr) != 0) mem[d][ad(d, s_wr_addr)] = s_wr_data;
          bsy[d][ad(d, s_wr_addr)] = 1'b0;
        end
        if (s_iss_en && ad(d, s_iss_addr) != 0) bsy[d][ad(d, s_iss_addr)] = 1'b1;
      end
    end
  endtask

  // ---------------- stimulus / checking ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive();
    ifa.rd_addr  = {s_rd[1], s_rd[0]};
    ifb.rd_addr  = {s_rd[3][3:0], s_rd[2][3:0], s_rd[1][3:0], s_rd[0][3:0]};
    ifa.iss_en   = s_iss_en;          ifb.iss_en   = s_iss_en;
    ifa.iss_addr = s_iss_addr;        ifb.iss_addr = s_iss_addr[3:0];
    ifa.wr_en    = s_wr_en;           ifb.wr_en    = s_wr_en;
    ifa.wr_addr  = s_wr_addr;         ifb.wr_addr  = s_wr_addr[3:0];
    ifa.wr_data  = s_wr_data;         ifb.wr_data  = s_wr_data;
    ifa.dbg_addr = s_dbg;             ifb.dbg_addr = s_dbg[3:0];
  endtask

  task automatic idle_stim();
    for (int i = 0; i < 4; i++) s_rd[i] = 5'd0;
    s_iss_en = 1'b0; s_iss_addr = 5'd0;
    s_wr_en = 1'b0; s_wr_addr = 5'd0; s_wr_data = 32'h0;
    s_dbg = 5'd0;
  endtask

  task automatic rand_stim();
    s_wr_en    = ($urandom_range(0, 1) == 1);
    s_wr_addr  = 5'($urandom);
    s_wr_data  = $urandom;
    s_iss_en   = ($urandom_range(0, 2) == 0);
    s_iss_addr = ($urandom_range(0, 2) == 0) ? s_wr_addr : 5'($urandom);
    for (int i = 0; i < 4; i++)
      s_rd[i] = ($urandom_range(0, 3) == 0) ? s_wr_addr : 5'($urandom);
    s_dbg = 5'($urandom);
  endtask

  task automatic check_all();
    chk("a_init_done", 32'(ifa.init_done), 32'(mrun(0)));
    chk("b_init_done", 32'(ifb.init_done), 32'(mrun(1)));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("a_rd_data%0d", i), ifa.rd_data[i*32 +: 32], exp_rd(0, s_rd[i]));
      chk($sformatf("a_rd_busy%0d", i), 32'(ifa.rd_busy[i]), 32'(exp_busy(0, s_rd[i])));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_rd_data%0d", i), ifb.rd_data[i*32 +: 32], exp_rd(1, s_rd[i]));
      chk($sformatf("b_rd_busy%0d", i), 32'(ifb.rd_busy[i]), 32'(exp_busy(1, s_rd[i])));
    end
    chk("a_dbg_data", ifa.dbg_data, exp_dbg(0));
    chk("b_dbg_data", ifb.dbg_data, exp_dbg(1));
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  // Writes/issues driven during the first 15 clear cycles must be ignored by both configs
  task automatic sweep();
    int rise_a, rise_b;
    rise_a = -1;
    rise_b = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k <= 15) rand_stim();
      else         idle_stim();
      step();
      if (rise_a < 0 && ifa.init_done) rise_a = k;
      if (rise_b < 0 && ifb.init_done) rise_b = k;
      if (rise_a >= 0 && rise_b >= 0) break;
    end
    chk("a_init_rise_cycle", 32'(rise_a), 32'd32);
    chk("b_init_rise_cycle", 32'(rise_b), 32'd16);
  endtask

  task automatic run_table();
    for (int n = 0; n < 13; n++) begin
      idle_stim();
      s_wr_en = tbl[n].we; s_wr_addr = tbl[n].wa; s_wr_data = tbl[n].wd;
      s_iss_en = tbl[n].ie; s_iss_addr = tbl[n].ia;
      s_rd[0] = tbl[n].r0; s_rd[1] = tbl[n].r1; s_dbg = tbl[n].dbg;
      drive();
      @(negedge clk);
      chk($sformatf("vec%0d_a_rd0", n), ifa.rd_data[31:0], tbl[n].a0);
      chk($sformatf("vec%0d_a_rd1", n), ifa.rd_data[63:32], tbl[n].a1);
      chk($sformatf("vec%0d_a_busy0", n), 32'(ifa.rd_busy[0]), 32'(tbl[n].abz));
      chk($sformatf("vec%0d_a_dbg", n), ifa.dbg_data, tbl[n].adbg);
      chk($sformatf("vec%0d_b_rd0", n), ifb.rd_data[31:0], tbl[n].b0);
      chk($sformatf("vec%0d_b_rd1", n), ifb.rd_data[63:32], tbl[n].b1);
      chk($sformatf("vec%0d_b_busy0", n), 32'(ifb.rd_busy[0]), 32'(tbl[n].bbz));
      chk($sformatf("vec%0d_b_dbg", n), ifb.dbg_data, tbl[n].adbg);
      check_all();
      @(posedge clk);
      model_clock();
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //                we  wa     wd            ie  ia     r0     r1     dbg    a0            a1            abz adbg          b0            b1            bbz
    tbl[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0);
    tbl[1]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    tbl[2]  = mk(1, 5'd7, 32'h1234,     0, 5'd0, 5'd5, 5'd7, 5'd7, 32'hDEADBEEF, 32'h1234,     0, 32'h0,        32'hDEADBEEF, 32'h0,        0);
    tbl[3]  = mk(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd7, 5'd0, 32'h0,        32'h1234,     0, 32'h0,        32'h0,        32'h1234,     0);
    tbl[4]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd7, 5'd7, 32'h0,        32'h1234,     0, 32'h1234,     32'h0,        32'h1234,     0);
    tbl[5]  = mk(0, 5'd0, 32'h0,        1, 5'd9, 5'd9, 5'd5, 5'd9, 32'h0,        32'hDEADBEEF, 0, 32'h0,        32'h0,        32'hDEADBEEF, 0);
    tbl[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd0, 5'd9, 32'h0,        32'h0,        1, 32'h0,        32'h0,        32'h0,        1);
    tbl[7]  = mk(1, 5'd9, 32'hCAFE,     0, 5'd0, 5'd9, 5'd9, 5'd9, 32'hCAFE,     32'hCAFE,     0, 32'h0,        32'h0,        32'h0,        1);
    tbl[8]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd9, 5'd9, 32'hCAFE,     32'hCAFE,     0, 32'hCAFE,     32'hCAFE,     32'hCAFE,     0);
    tbl[9]  = mk(1, 5'd9, 32'h5555,     1, 5'd9, 5'd9, 5'd5, 5'd9, 32'h5555,     32'hDEADBEEF, 0, 32'hCAFE,     32'hCAFE,     32'hDEADBEEF, 0);
    tbl[10] = mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd0, 5'd9, 32'h5555,     32'h0,        1, 32'h5555,     32'h5555,     32'h0,        1);
    tbl[11] = mk(1, 5'd9, 32'h7777,     0, 5'd0, 5'd9, 5'd9, 5'd9, 32'h7777,     32'h7777,     0, 32'h5555,     32'h5555,     32'h5555,     1);
    tbl[12] = mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd0, 5'd0, 32'h7777,     32'h0,        0, 32'h0,        32'h7777,     32'h0,        0);

    reset = 1'b1;
    idle_stim();
    drive();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    sweep();

    for (int k = 0; k < 32; k++) begin
      idle_stim();
      s_dbg   = 5'(k);
      s_rd[0] = 5'(k);
      s_rd[1] = 5'(31 - k);
      step();
    end

    run_table();
    for (int n = 0; n < 300; n++) begin
      rand_stim();
      step();
    end

    // Abort the sweep part-way with an asynchronous reset
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      rand_stim();
      step();
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    sweep();

    run_table();
    for (int n = 0; n < 200; n++) begin
      rand_stim();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
